// File: rtl/tri_upload_ctrl.sv
// Framing/commit controller: parses sync + payload + XOR checksum from the UART byte stream,
// writes the shadow bank, and commits shadow to active only on a frame boundary.
module tri_upload_ctrl #(
   parameter int unsigned PAYLOAD_LEN    = 54,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned TO_W           = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       frame_start,
   output logic       wr_en,
   output logic [5:0] wr_idx,
   output logic [7:0] wr_data,
   output logic       commit,
   output logic       pending,
   output logic       busy,
   output logic       pkt_err,
   output logic [7:0] drop_cnt
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PAYLOAD = 2'd1;
   localparam logic [1:0] S_CHECK   = 2'd2;
   localparam logic [1:0] S_PEND    = 2'd3;

   localparam logic [5:0]      LAST_IDX = 6'(PAYLOAD_LEN - 1);
   localparam logic [TO_W-1:0] TO_TERM  = TO_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]      state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [7:0]      xor_q, xor_d;
   logic [TO_W-1:0] gap_q, gap_d;
   logic            wr_en_d, commit_d, pkt_err_d;
   logic [5:0]      wr_idx_d;
   logic [7:0]      wr_data_d, drop_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      xor_d     = xor_q;
      gap_d     = gap_q;
      wr_en_d   = 1'b0;
      wr_idx_d  = wr_idx;
      wr_data_d = wr_data;
      commit_d  = 1'b0;
      pkt_err_d = pkt_err;
      drop_d    = drop_cnt;
      case (state_q)
         S_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
               state_d = S_PAYLOAD;
               cnt_d   = '0;
               xor_d   = '0;
               gap_d   = '0;
            end
         end
         S_PAYLOAD, S_CHECK: begin
            // A byte arriving on the terminal gap count takes priority over the timeout.
            if (rx_valid) begin
               gap_d = '0;
               if (state_q == S_PAYLOAD) begin
                  wr_en_d   = 1'b1;
                  wr_idx_d  = cnt_q;
                  wr_data_d = rx_data;
                  xor_d     = xor_q ^ rx_data;
                  cnt_d     = cnt_q + 6'd1;
                  if (cnt_q == LAST_IDX) state_d = S_CHECK;
               end else if (rx_data == xor_q) begin
                  state_d   = S_PEND;
                  pkt_err_d = 1'b0;
               end else begin
                  state_d   = S_IDLE;
                  pkt_err_d = 1'b1;
               end
            end else if (gap_q == TO_TERM) begin
               state_d   = S_IDLE;
               pkt_err_d = 1'b1;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_PEND: begin
            if (rx_valid && drop_cnt != 8'hFF) drop_d = drop_cnt + 8'd1;
            if (frame_start) begin
               commit_d = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         xor_q    <= '0;
         gap_q    <= '0;
         wr_en    <= 1'b0;
         wr_idx   <= '0;
         wr_data  <= '0;
         commit   <= 1'b0;
         pending  <= 1'b0;
         busy     <= 1'b0;
         pkt_err  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         xor_q    <= xor_d;
         gap_q    <= gap_d;
         wr_en    <= wr_en_d;
         wr_idx   <= wr_idx_d;
         wr_data  <= wr_data_d;
         commit   <= commit_d;
         pending  <= (state_d == S_PEND);
         busy     <= (state_d == S_PAYLOAD) || (state_d == S_CHECK);
         pkt_err  <= pkt_err_d;
         drop_cnt <= drop_d;
      end
   end

endmodule

// File: tb/tb_tri_upload_ctrl.sv
// Bench for tri_upload_ctrl: directed scenarios plus randomized packets, checked every cycle
// against a queue-based packet model.
module tb_tri_upload_ctrl;

   localparam int unsigned LEN = 54;
   localparam int unsigned TO  = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       frame_start = 1'b0;
   logic       wr_en, commit, pending, busy, pkt_err;
   logic [5:0] wr_idx;
   logic [7:0] wr_data, drop_cnt;

   tri_upload_ctrl #(
      .PAYLOAD_LEN(LEN),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT_CYCLES(TO),
      .TO_W(20)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .frame_start(frame_start),
      .wr_en(wr_en),
      .wr_idx(wr_idx),
      .wr_data(wr_data),
      .commit(commit),
      .pending(pending),
      .busy(busy),
      .pkt_err(pkt_err),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int wr_seen = 0;
   bit chk_on = 1'b0;

   // Packet-level model: collected payload, held-packet flag, silent-cycle count.
   byte unsigned pay[$];
   bit  in_pkt = 1'b0;
   bit  held = 1'b0;
   int  silent = 0;
   bit        e_wr_en = 1'b0, e_commit = 1'b0, e_err = 1'b0;
   logic [5:0] e_wr_idx = '0;
   logic [7:0] e_wr_data = '0, e_drop = '0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit rv, input logic [7:0] rd, input bit fs);
      logic [7:0] x;
      e_wr_en  = 1'b0;
      e_commit = 1'b0;
      if (rst) begin
         in_pkt = 0; held = 0; silent = 0; e_err = 0;
         e_drop = '0; e_wr_idx = '0; e_wr_data = '0;
         pay.delete();
      end else if (held) begin
         if (rv && e_drop != 8'hFF) e_drop = e_drop + 8'd1;
         if (fs) begin
            e_commit = 1'b1;
            held = 0;
         end
      end else if (in_pkt) begin
         if (rv) begin
            silent = 0;
            if (pay.size() < LEN) begin
               e_wr_en   = 1'b1;
               e_wr_idx  = 6'(pay.size());
               e_wr_data = rd;
               pay.push_back(rd);
            end else begin
               x = 8'h00;
               foreach (pay[i]) x = x ^ pay[i];
               if (rd == x) begin
                  held  = 1;
                  e_err = 0;
               end else begin
                  e_err = 1;
               end
               in_pkt = 0;
            end
         end else begin
            silent++;
            if (silent == TO) begin
               e_err  = 1;
               in_pkt = 0;
            end
         end
      end else if (rv && rd == 8'hA5) begin
         in_pkt = 1;
         silent = 0;
         pay.delete();
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("wr_en", {7'd0, wr_en}, {7'd0, e_wr_en});
         if (e_wr_en) begin
            chk("wr_idx", {2'd0, wr_idx}, {2'd0, e_wr_idx});
            chk("wr_data", wr_data, e_wr_data);
         end
         chk("commit", {7'd0, commit}, {7'd0, e_commit});
         chk("pending", {7'd0, pending}, {7'd0, held});
         chk("busy", {7'd0, busy}, {7'd0, in_pkt});
         chk("pkt_err", {7'd0, pkt_err}, {7'd0, e_err});
         chk("drop_cnt", drop_cnt, e_drop);
         if (wr_en) wr_seen++;
      end
   end

   task automatic cyc(input bit rv, input logic [7:0] rd, input bit fs);
      rx_valid    = rv;
      rx_data     = rd;
      frame_start = fs;
      @(posedge clk);
      model_step(reset, rv, rd, fs);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) cyc(1'b0, 8'h00, 1'b0);
      reset = 1'b0;
   endtask

   task automatic idle(input int n, input bit rnd_fs);
      repeat (n) cyc(1'b0, 8'($urandom), rnd_fs && ($urandom_range(7) == 0));
   endtask

   // Sends A5 + payload + checksum; payload is the index or random, checksum optionally corrupt.
   task automatic send_pkt(input bit rnd, input bit bad, input bit fs_on_ck, input int max_gap);
      logic [7:0] b, x;
      x = 8'h00;
      cyc(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < int'(LEN); i++) begin
         idle($urandom_range(max_gap), 1'b1);
         b = rnd ? 8'($urandom) : 8'(i);
         x = x ^ b;
         cyc(1'b1, b, 1'b0);
      end
      idle($urandom_range(max_gap), 1'b1);
      cyc(1'b1, bad ? (x ^ 8'h01) : x, fs_on_ck);
   endtask

   int w0;

   initial begin
      do_reset(3);
      chk_on = 1'b1;
      chk("rst_wr_en", {7'd0, wr_en}, 8'd0);
      chk("rst_drop", drop_cnt, 8'd0);

      // Good packet: index payload, checksum of 0..53 is 0x01.
      w0 = wr_seen;
      send_pkt(1'b0, 1'b0, 1'b0, 0);
      chk("good_wr_count", 8'(wr_seen - w0), 8'd54);
      chk("good_pending", {7'd0, pending}, 8'd1);
      chk("good_no_commit", {7'd0, commit}, 8'd0);
      idle(5, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("good_commit", {7'd0, commit}, 8'd1);
      chk("good_pend_clr", {7'd0, pending}, 8'd0);
      idle(1, 1'b0);
      chk("good_commit_once", {7'd0, commit}, 8'd0);

      // Bad checksum, then a good packet clears the error.
      send_pkt(1'b0, 1'b1, 1'b0, 1);
      chk("bad_err", {7'd0, pkt_err}, 8'd1);
      chk("bad_pending", {7'd0, pending}, 8'd0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("bad_no_commit", {7'd0, commit}, 8'd0);
      send_pkt(1'b1, 1'b0, 1'b0, 1);
      chk("bad_err_clr", {7'd0, pkt_err}, 8'd0);
      cyc(1'b0, 8'h00, 1'b1);
      idle(2, 1'b0);

      // Timeout after 10 payload bytes, then restart from index 0.
      cyc(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i + 8'h40), 1'b0);
      idle(TO, 1'b0);
      chk("to_err", {7'd0, pkt_err}, 8'd1);
      chk("to_busy", {7'd0, busy}, 8'd0);
      cyc(1'b1, 8'hA5, 1'b0);
      cyc(1'b1, 8'h77, 1'b0);
      chk("to_restart_idx", {2'd0, wr_idx}, 8'd0);
      idle(TO + 2, 1'b0);

      // Drops while pending saturate at 255; sync bytes among them are ignored.
      send_pkt(1'b0, 1'b0, 1'b0, 0);
      w0 = wr_seen;
      for (int i = 0; i < 300; i++) cyc(1'b1, (i % 7 == 0) ? 8'hA5 : 8'($urandom), 1'b0);
      chk("drop_sat", drop_cnt, 8'hFF);
      chk("drop_no_wr", 8'(wr_seen - w0), 8'd0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("drop_commit", {7'd0, commit}, 8'd1);
      cyc(1'b1, 8'hA5, 1'b0);
      chk("drop_resync", {7'd0, busy}, 8'd1);
      idle(TO + 2, 1'b0);

      // frame_start coincident with checksum accept is ignored.
      send_pkt(1'b1, 1'b0, 1'b1, 0);
      chk("coin_no_commit", {7'd0, commit}, 8'd0);
      chk("coin_pending", {7'd0, pending}, 8'd1);
      idle(3, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("coin_commit", {7'd0, commit}, 8'd1);

      // Reset mid-packet.
      cyc(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom), 1'b0);
      do_reset(2);
      chk("mid_rst_busy", {7'd0, busy}, 8'd0);
      chk("mid_rst_drop", drop_cnt, 8'd0);
      chk("mid_rst_wr", {7'd0, wr_en}, 8'd0);
      w0 = wr_seen;
      send_pkt(1'b0, 1'b0, 1'b0, 0);
      chk("mid_rst_wr_count", 8'(wr_seen - w0), 8'd54);
      chk("mid_rst_pending", {7'd0, pending}, 8'd1);
      cyc(1'b0, 8'h00, 1'b1);
      chk("mid_rst_commit", {7'd0, commit}, 8'd1);

      // Randomized traffic: mixed packets, noise, frame pulses and occasional timeouts.
      for (int n = 0; n < 40; n++) begin
         send_pkt(1'b1, $urandom_range(3) == 0, $urandom_range(5) == 0, 2);
         for (int k = 0; k < int'($urandom_range(20)); k++)
            cyc($urandom_range(2) == 0, ($urandom_range(9) == 0) ? 8'hA5 : 8'($urandom),
                $urandom_range(5) == 0);
         if ($urandom_range(7) == 0) idle(TO + 1, 1'b0);
         idle($urandom_range(30), 1'b1);
      end

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
